// File: rtl/seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Registered, digit-serial magnitude comparator. It compares two WIDTH-bit
// operands DIGIT bits per clock, starting with the most significant digit.
// Valid/ready handshakes are used on both the input and output sides. Only one
// comparison is in flight at a time.
//
// Parameters
//   WIDTH  : operand width in bits (must be a multiple of DIGIT)
//   DIGIT  : number of bits compared per cycle; NDIG = WIDTH/DIGIT
//   SIGNED : 0 = unsigned compare, 1 = two's-complement compare
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, active low
//   in_valid   : operands a/b are valid
//   in_ready   : block can accept operands (high only in IDLE)
//   a, b       : operands
//   out_valid  : result is valid; held until out_ready is seen
//   out_ready  : consumer accepts the result
//   greater    : A > B (held while out_valid is high)
//   equal      : A == B
//   less       : A < B
//
// Build option
//   CMP_EARLY_EXIT_EN : when defined, the compare finishes on the first
//                       differing digit. When undefined, every compare takes
//                       exactly NDIG cycles (constant time).
// -----------------------------------------------------------------------------
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGIT  = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             greater,
  output logic             equal,
  output logic             less
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Flipping the sign bit maps two's-complement onto offset binary, so the
  // digit-serial unsigned compare gives the signed ordering.
  localparam logic [WIDTH-1:0] MSB_FLIP =
    (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [CW-1:0]     cnt_q;
  logic              gt_q, lt_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              greater_q, equal_q, less_q;

  logic [DIGIT-1:0]  dig_a, dig_b;
  logic              decided;
  logic              gt_d, lt_d;
  logic              finish;

  always_comb begin
    dig_a   = a_q[WIDTH-1 -: DIGIT];
    dig_b   = b_q[WIDTH-1 -: DIGIT];
    decided = gt_q | lt_q;
    // Sticky: once a digit has differed, later digits are ignored.
    gt_d    = gt_q | (~decided & (dig_a > dig_b));
    lt_d    = lt_q | (~decided & (dig_a < dig_b));
`ifdef CMP_EARLY_EXIT_EN
    finish  = (cnt_q == '0) | gt_d | lt_d;
`else
    finish  = (cnt_q == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      greater_q   <= 1'b0;
      equal_q     <= 1'b0;
      less_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a ^ MSB_FLIP;
            b_q        <= b ^ MSB_FLIP;
            cnt_q      <= CW'(NDIG - 1);
            gt_q       <= 1'b0;
            lt_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          a_q   <= a_q << DIGIT;
          b_q   <= b_q << DIGIT;
          cnt_q <= cnt_q - CW'(1);
          gt_q  <= gt_d;
          lt_q  <= lt_d;
          if (finish) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            greater_q   <= gt_d;
            less_q      <= lt_d;
            equal_q     <= ~(gt_d | lt_d);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            greater_q   <= 1'b0;
            equal_q     <= 1'b0;
            less_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          greater_q   <= 1'b0;
          equal_q     <= 1'b0;
          less_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign greater   = greater_q;
  assign equal     = equal_q;
  assign less      = less_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// tb_seq_magnitude_comparator
//
// Directed bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4). There are
// two instances that share their inputs: one unsigned and one signed. Results
// are encoded as {greater, equal, less}.
// -----------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a, b;
  logic        rdy_u, ov_u, g_u, e_u, l_u;
  logic        rdy_s, ov_s, g_s, e_s, l_s;

  int unsigned total;
  int unsigned bad;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
    .a(a), .b(b), .out_valid(ov_u), .out_ready(out_ready),
    .greater(g_u), .equal(e_u), .less(l_u)
  );

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
    .a(a), .b(b), .out_valid(ov_s), .out_ready(out_ready),
    .greater(g_s), .equal(e_s), .less(l_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [2:0]  exp_u;
    logic [2:0]  exp_s;
    int          lat_ee;
  } vec_t;

  // {greater, equal, less}; lat_ee = latency with early exit enabled.
  vec_t vecs [7] = '{
    '{16'h9000, 16'h5000, 3'b100, 3'b001, 1},
    '{16'hC3C3, 16'hC3C3, 3'b010, 3'b010, 4},
    '{16'h0004, 16'h0009, 3'b001, 3'b001, 4},
    '{16'h1F00, 16'h20FF, 3'b001, 3'b001, 1},
    '{16'hFFFF, 16'h0001, 3'b100, 3'b001, 1},
    '{16'h8000, 16'h7FFF, 3'b100, 3'b001, 1},
    '{16'h1234, 16'h1244, 3'b001, 3'b001, 3}
  };

  // Drive one accept and wait (bounded) until both instances present a result.
  task automatic run_txn(input logic [15:0] va, input logic [15:0] vb,
                         output int lat_u, output int lat_s,
                         output logic [2:0] res_u, output logic [2:0] res_s,
                         output bit timeout);
    int n;
    @(negedge clk);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    lat_u = 0;
    lat_s = 0;
    timeout = 1'b0;
    while (!(ov_u && ov_s)) begin
      if (n >= 40) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
      if (ov_u && lat_u == 0) lat_u = n;
      if (ov_s && lat_s == 0) lat_s = n;
    end
    res_u = {g_u, e_u, l_u};
    res_s = {g_s, e_s, l_s};
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rdy_u, ov_u, g_u, e_u, l_u} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_u: got rdy/ov/g/e/l=%b want 10000", {rdy_u, ov_u, g_u, e_u, l_u});
    end
    total++;
    if ({rdy_s, ov_s, g_s, e_s, l_s} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_s: got rdy/ov/g/e/l=%b want 10000", {rdy_s, ov_s, g_s, e_s, l_s});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    int lu, ls, want_lat;
    logic [2:0] ru, rs;
    bit to;
    foreach (vecs[i]) begin
      want_lat = EE ? vecs[i].lat_ee : 4;
      run_txn(vecs[i].va, vecs[i].vb, lu, ls, ru, rs, to);
      total++;
      if (to) begin
        bad++;
        $display("FAIL vec%0d_timeout: out_valid never rose", i);
      end
      total++;
      if (ru !== vecs[i].exp_u) begin
        bad++;
        $display("FAIL vec%0d_unsigned: got gel=%b want %b", i, ru, vecs[i].exp_u);
      end
      total++;
      if (rs !== vecs[i].exp_s) begin
        bad++;
        $display("FAIL vec%0d_signed: got gel=%b want %b", i, rs, vecs[i].exp_s);
      end
      total++;
      if (lu != want_lat || ls != want_lat) begin
        bad++;
        $display("FAIL vec%0d_latency: got u=%0d s=%0d want %0d", i, lu, ls, want_lat);
      end
      handshake();
      total++;
      if ({rdy_u, ov_u, g_u, e_u, l_u, rdy_s, ov_s} !== 7'b1000010) begin
        bad++;
        $display("FAIL vec%0d_release: got %b want 1000010", i,
                 {rdy_u, ov_u, g_u, e_u, l_u, rdy_s, ov_s});
      end
    end
  endtask

  task automatic test_back_pressure();
    int lu, ls;
    logic [2:0] ru, rs;
    bit to;
    run_txn(16'h9000, 16'h5000, lu, ls, ru, rs, to);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = 16'h0000;
      b = 16'hFFFF;
      in_valid = (k % 2) == 0;
      @(posedge clk);
      #1;
      total++;
      if ({ov_u, g_u, e_u, l_u, rdy_u, ov_s, g_s, e_s, l_s, rdy_s} !== 10'b1100010010) begin
        bad++;
        $display("FAIL backpressure_hold%0d: got %b want 1100010010", k,
                 {ov_u, g_u, e_u, l_u, rdy_u, ov_s, g_s, e_s, l_s, rdy_s});
      end
    end
    in_valid = 1'b0;
    handshake();
    total++;
    if ({ov_u, rdy_u, ov_s, rdy_s} !== 4'b0101) begin
      bad++;
      $display("FAIL backpressure_release: got ov/rdy=%b want 0101", {ov_u, rdy_u, ov_s, rdy_s});
    end
    run_txn(16'h0004, 16'h0009, lu, ls, ru, rs, to);
    total++;
    if (to || ru !== 3'b001 || rs !== 3'b001) begin
      bad++;
      $display("FAIL backpressure_next: got u=%b s=%b to=%0d want 001 001 0", ru, rs, to);
    end
    handshake();
  endtask

  task automatic test_reset_mid_busy();
    int lu, ls;
    logic [2:0] ru, rs;
    bit to;
    @(negedge clk);
    a = 16'hC3C3;
    b = 16'hC3C3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if ({rdy_u, ov_u, g_u, e_u, l_u} !== 5'b00000) begin
      bad++;
      $display("FAIL busy_outputs: got rdy/ov/g/e/l=%b want 00000", {rdy_u, ov_u, g_u, e_u, l_u});
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rdy_u, ov_u, g_u, e_u, l_u, rdy_s, ov_s} !== 7'b1000010) begin
      bad++;
      $display("FAIL midbusy_reset: got %b want 1000010",
               {rdy_u, ov_u, g_u, e_u, l_u, rdy_s, ov_s});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      total++;
      if (ov_u !== 1'b0 || ov_s !== 1'b0) begin
        bad++;
        $display("FAIL midbusy_abandon: got out_valid u=%b s=%b want 0 0", ov_u, ov_s);
      end
    end
    run_txn(16'hFFFF, 16'h0000, lu, ls, ru, rs, to);
    total++;
    if (to || ru !== 3'b100 || rs !== 3'b001) begin
      bad++;
      $display("FAIL after_reset: got u=%b s=%b to=%0d want 100 001 0", ru, rs, to);
    end
    handshake();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_vectors();
    test_back_pressure();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
